instr_encoder: RTL and testbench



---
 rtl/instr_encoder_pkg.sv | 40 ++++
 rtl/instr_encoder_if.sv | 29 ++
 rtl/instr_field_pack.sv | 51 +++++
 rtl/instr_encoder.sv | 109 ++++++++++
 tb/tb_instr_encoder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the instruction encoder: opcodes, request kinds,
// the NOP word and the signed immediate limits.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Full 64-bit signed limits; comparing against these is the same as
    // requiring all bits above the immediate width to match the sign bit.
    localparam logic signed [63:0] IMM_I_MIN = -64'sd2048;
    localparam logic signed [63:0] IMM_I_MAX = 64'sd2047;
    localparam logic signed [63:0] IMM_B_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM_B_MAX = 64'sd4094;

    typedef enum logic [1:0] {
        KIND_LOAD   = 2'b00,
        KIND_STORE  = 2'b01,
        KIND_BRANCH = 2'b10,
        KIND_RSVD   = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [63:0] offset;
    } req_t;

    function automatic logic in_range(input logic signed [63:0] v,
                                      input logic signed [63:0] lo,
                                      input logic signed [63:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder. master = program generator
// and instruction-memory sink, slave = the encoder.
interface instr_encoder_if;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [63:0] in_offset;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        out_err;
    logic [15:0] err_count;

    modport master (
        output restart, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_offset, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );

    modport slave (
        input  restart, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_offset, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_count
    );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packer: places the byte offset into the I/S/B immediate slots and
// substitutes a NOP with err set when the request cannot be encoded.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  kind_e       i_kind,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_offset,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic        w_fit_i;
    logic        w_fit_b;
    logic [31:0] w_word;
    logic        w_bad;

    assign w_fit_i = in_range($signed(i_offset), IMM_I_MIN, IMM_I_MAX);
    assign w_fit_b = in_range($signed(i_offset), IMM_B_MIN, IMM_B_MAX) && !i_offset[0];

    always_comb begin
        w_word = NOP_INSTR;
        w_bad  = 1'b1;
        case (i_kind)
            KIND_LOAD: begin
                w_word = {i_offset[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
                w_bad  = !w_fit_i;
            end
            KIND_STORE: begin
                w_word = {i_offset[11:5], i_rs2, i_rs1, i_funct3, i_offset[4:0], OPC_STORE};
                w_bad  = !w_fit_i;
            end
            KIND_BRANCH: begin
                w_word = {i_offset[12], i_offset[10:5], i_rs2, i_rs1, i_funct3,
                          i_offset[4:1], i_offset[11], OPC_BRANCH};
                w_bad  = !w_fit_b;
            end
            default: begin
                w_word = NOP_INSTR;
                w_bad  = 1'b1;
            end
        endcase
    end

    assign o_instr = w_bad ? NOP_INSTR : w_word;
    assign o_err   = w_bad;

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 holds the request and its address slot, S2 holds
// the packed word; each stage stalls independently under output back-pressure.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] ADDR_STEP = 64'd4
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);

    req_t        w_req;
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_in_hs;
    logic        w_out_hs;
    logic [31:0] w_pack_instr;
    logic        w_pack_err;

    req_t        r_s1_req;
    logic        r_s1_valid;
    logic [63:0] r_s1_addr;
    logic        r_s2_valid;
    logic [31:0] r_out_instr;
    logic [63:0] r_out_addr;
    logic        r_out_err;
    logic [15:0] r_err_count;
    logic [63:0] r_addr_cnt;

    always_comb begin
        w_req        = '0;
        w_req.kind   = kind_e'(bus.in_kind);
        w_req.rd     = bus.in_rd;
        w_req.rs1    = bus.in_rs1;
        w_req.rs2    = bus.in_rs2;
        w_req.funct3 = bus.in_funct3;
        w_req.offset = bus.in_offset;
    end

    // An empty S2 always advances, so S1 advancing reduces to S2 advancing.
    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = w_s2_adv;
    assign w_in_ready = !rst && !bus.restart && (!r_s1_valid || w_s1_adv);
    assign w_in_hs    = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_s2_valid && bus.out_ready;

    instr_field_pack u_pack (
        .i_kind   (r_s1_req.kind),
        .i_rd     (r_s1_req.rd),
        .i_rs1    (r_s1_req.rs1),
        .i_rs2    (r_s1_req.rs2),
        .i_funct3 (r_s1_req.funct3),
        .i_offset (r_s1_req.offset),
        .o_instr  (w_pack_instr),
        .o_err    (w_pack_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_req    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= BASE_ADDR;
            r_s2_valid  <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= BASE_ADDR;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
            r_addr_cnt  <= BASE_ADDR;
        end else if (bus.restart) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_err_count <= '0;
            r_addr_cnt  <= BASE_ADDR;
        end else begin
            if (w_in_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_req   <= w_req;
                r_s1_addr  <= r_addr_cnt;
                r_addr_cnt <= r_addr_cnt + ADDR_STEP;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_instr <= w_pack_instr;
                    r_out_addr  <= r_s1_addr;
                    r_out_err   <= w_pack_err;
                end
            end

            if (w_out_hs && r_out_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_err   = r_out_err;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table vectors, hand-written corner sequences
// and randomized traffic scored against an arithmetic reference model.
module tb_instr_encoder;

    localparam logic [63:0] BASE  = 64'h0;
    localparam logic [63:0] WBASE = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if bus ();
    instr_encoder_if bus_w ();

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(64'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_encoder #(.BASE_ADDR(WBASE), .ADDR_STEP(64'd4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [63:0] addr;
        logic [63:0] off;
    } exp_t;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [63:0] off;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        q[$];
    exp_t        mon_e;
    vec_t        tbl[13];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    logic [63:0] mdl_addr = BASE;
    int          mdl_errs = 0;
    logic [31:0] tb_exp_instr = '0;
    logic        tb_exp_err = 1'b0;
    bit          rdy_rand = 1'b0;
    logic        rdy_val = 1'b1;
    bit          stall_prev = 1'b0;
    logic [31:0] st_instr;
    logic [63:0] st_addr;
    logic        st_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder: builds the word field by field with shifts and masks.
    function automatic void model(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] off,
                                  output logic [31:0] ins, output logic err);
        longint          v;
        longint unsigned o, w, ud, u1, u2, uf;
        bit              ok;
        v  = longint'(off);
        o  = off;
        ud = 64'(rd);
        u1 = 64'(rs1);
        u2 = 64'(rs2);
        uf = 64'(f3);
        ok = 1'b0;
        w  = 0;
        case (k)
            2'd0: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = ((o & 64'hFFF) << 20) | (u1 << 15) | (uf << 12) | (ud << 7) | 64'h03;
            end
            2'd1: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((o >> 5) & 64'h7F) << 25) | (u2 << 20) | (u1 << 15) | (uf << 12)
                     | ((o & 64'h1F) << 7) | 64'h23;
            end
            2'd2: begin
                ok = (v >= -4096) && (v <= 4094) && ((v % 2) == 0);
                w  = (((o >> 12) & 64'h1) << 31) | (((o >> 5) & 64'h3F) << 25) | (u2 << 20)
                     | (u1 << 15) | (uf << 12) | (((o >> 1) & 64'hF) << 8)
                     | (((o >> 11) & 64'h1) << 7) | 64'h63;
            end
            default: ok = 1'b0;
        endcase
        err = !ok;
        ins = ok ? w[31:0] : 32'h0000_0013;
    endfunction

    function automatic logic [63:0] decode_imm(input logic [31:0] w);
        case (w[6:0])
            7'b0000011: return {{52{w[31]}}, w[31:20]};
            7'b0100011: return {{52{w[31]}}, w[31:25], w[11:7]};
            7'b1100011: return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default:    return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] rand_off();
        longint x;
        longint lim[11] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 3, -3};
        case ($urandom_range(0, 4))
            0:       x = longint'(int'($urandom_range(0, 255)) - 128);
            1:       x = lim[$urandom_range(0, 10)];
            2:       x = longint'({$urandom, $urandom});
            3:       x = longint'(int'($urandom_range(0, 8191)) - 4096);
            default: x = longint'(int'($urandom_range(0, 1023)) * 2 - 1024);
        endcase
        return x;
    endfunction

    // Scoreboard: samples handshakes mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mdl_addr   = BASE;
            mdl_errs   = 0;
            stall_prev = 1'b0;
        end else begin
            chk("err_count", 64'(bus.err_count), 64'(mdl_errs));
            if (stall_prev) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_instr", 64'(bus.out_instr), 64'(st_instr));
                chk("hold_addr", bus.out_addr, st_addr);
                chk("hold_err", 64'(bus.out_err), 64'(st_err));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got instr %h addr %h, expected no word", bus.out_instr, bus.out_addr);
                end else begin
                    mon_e = q.pop_front();
                    n_pop++;
                    chk("out_instr", 64'(bus.out_instr), 64'(mon_e.instr));
                    chk("out_addr", bus.out_addr, mon_e.addr);
                    chk("out_err", 64'(bus.out_err), 64'(mon_e.err));
                    if (!mon_e.err) chk("roundtrip_imm", decode_imm(bus.out_instr), mon_e.off);
                    if (mon_e.err && mdl_errs < 65535) mdl_errs++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e.instr = tb_exp_instr;
                mon_e.err   = tb_exp_err;
                mon_e.addr  = mdl_addr;
                mon_e.off   = bus.in_offset;
                q.push_back(mon_e);
                mdl_addr = mdl_addr + 64'd4;
            end
            stall_prev = bus.out_valid && !bus.out_ready && !bus.restart;
            st_instr   = bus.out_instr;
            st_addr    = bus.out_addr;
            st_err     = bus.out_err;
            if (bus.restart) begin
                q.delete();
                mdl_addr = BASE;
                mdl_errs = 0;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] off,
                           input logic [31:0] ei, input logic ee);
        bus.in_kind   = k;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_offset = off;
        tb_exp_instr  = ei;
        tb_exp_err    = ee;
        bus.in_valid  = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the request.
    task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] off,
                        input logic [31:0] ei, input logic ee);
        set_req(k, rd, rs1, rs2, f3, off, ei, ee);
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (c > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", c);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] off);
        logic [31:0] ei;
        logic        ee;
        model(k, rd, rs1, rs2, f3, off, ei, ee);
        send(k, rd, rs1, rs2, f3, off, ei, ee);
    endtask

    task automatic send_rand(input bit any_kind);
        logic [1:0] k;
        k = any_kind ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        send_model(k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rand_off());
    endtask

    task automatic drain();
        for (int c = 0; c < 2000 && q.size() != 0; c++) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        tbl[0]  = '{2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd8,                   32'h00813283, 1'b0};
        tbl[1]  = '{2'd1, 5'd0, 5'd1, 5'd7, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE70BE23, 1'b0};
        tbl[2]  = '{2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFE208CE3, 1'b0};
        tbl[3]  = '{2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 64'd4094,                32'h7E000FE3, 1'b0};
        tbl[4]  = '{2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'd4096,                32'h00000013, 1'b1};
        tbl[5]  = '{2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 64'd3,                   32'h00000013, 1'b1};
        tbl[6]  = '{2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 64'd2048,                32'h00000013, 1'b1};
        tbl[7]  = '{2'd3, 5'd5, 5'd2, 5'd0, 3'd3, 64'd0,                   32'h00000013, 1'b1};
        tbl[8]  = '{2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_F800, 32'h80000023, 1'b0};
        tbl[9]  = '{2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_F000, 32'h80000063, 1'b0};
        tbl[10] = '{2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_F7FF, 32'h00000013, 1'b1};
        tbl[11] = '{2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 64'h0000_0001_0000_0008, 32'h00000013, 1'b1};
        tbl[12] = '{2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 64'd2047,                32'h7FF00003, 1'b0};

        bus.restart = 1'b0;  bus.in_valid = 1'b0;  bus.in_kind = '0;  bus.in_rd = '0;
        bus.in_rs1 = '0;  bus.in_rs2 = '0;  bus.in_funct3 = '0;  bus.in_offset = '0;
        bus_w.restart = 1'b0;  bus_w.in_valid = 1'b0;  bus_w.in_kind = '0;  bus_w.in_rd = '0;
        bus_w.in_rs1 = '0;  bus_w.in_rs2 = '0;  bus_w.in_funct3 = '0;  bus_w.in_offset = '0;
        bus_w.out_ready = 1'b1;

        // Reset values while rst is held
        #12;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_addr", bus.out_addr, BASE);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_err_count", 64'(bus.err_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: handshake in cycle N, out_valid in N+2
        set_req(tbl[0].kind, tbl[0].rd, tbl[0].rs1, tbl[0].rs2, tbl[0].f3, tbl[0].off, tbl[0].instr, tbl[0].err);
        @(negedge clk);
        chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_n2_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 1; i <= 7; i++)
            send(tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].off, tbl[i].instr, tbl[i].err);
        drain();
        chk("err_count_4", 64'(bus.err_count), 64'd4);
        for (int i = 8; i <= 12; i++)
            send(tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].off, tbl[i].instr, tbl[i].err);
        drain();
        chk("err_count_6", 64'(bus.err_count), 64'd6);

        // Restart with both stages full and a request pending
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send_model(2'd0, 5'd1, 5'd2, 5'd0, 3'd2, 64'd4);
        send_model(2'd1, 5'd0, 5'd2, 5'd3, 3'd2, 64'd20);
        chk("rs_pre_valid", 64'(bus.out_valid), 64'd1);
        set_req(2'd0, 5'd9, 5'd9, 5'd0, 3'd0, 64'd16, 32'h0, 1'b0);
        bus.restart = 1'b1;
        @(negedge clk);
        chk("rs_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.restart  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_err_count", 64'(bus.err_count), 64'd0);
        chk("rs_in_ready_after", 64'(bus.in_ready), 64'd1);
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        send_model(2'd0, 5'd4, 5'd3, 5'd0, 3'd3, 64'd12);
        drain();

        // Back-pressure burst of 8
        rdy_rand = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 8; i++) send_rand(1'b0);
        drain();
        chk("bp_count", 64'(n_pop - p0), 64'd8);

        // Random traffic with gaps
        for (int i = 0; i < 150; i++) begin
            send_rand(1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;

        // Asynchronous reset mid-stream
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send_model(2'd0, 5'd3, 5'd4, 5'd0, 3'd2, 64'd8);
        send_model(2'd2, 5'd0, 5'd4, 5'd5, 3'd1, 64'd16);
        chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_in_ready", 64'(bus.in_ready), 64'd0);
        chk("ar_out_instr", 64'(bus.out_instr), 64'd0);
        chk("ar_out_addr", bus.out_addr, BASE);
        chk("ar_out_err", 64'(bus.out_err), 64'd0);
        chk("ar_err_count", 64'(bus.err_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rdy_val = 1'b1;
        @(negedge clk);
        chk("ar_in_ready_after", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Address wrap on the instance based at 2^64-4
        bus_w.in_valid = 1'b1;
        bus_w.in_kind  = 2'd0;
        bus_w.in_rd    = 5'd1;
        @(negedge clk);
        chk("wrap_in_ready", 64'(bus_w.in_ready), 64'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus_w.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_valid0", 64'(bus_w.out_valid), 64'd1);
        chk("wrap_addr0", bus_w.out_addr, WBASE);
        chk("wrap_instr0", 64'(bus_w.out_instr), 64'h0000_0083);
        @(negedge clk);
        chk("wrap_valid1", 64'(bus_w.out_valid), 64'd1);
        chk("wrap_addr1", bus_w.out_addr, 64'h0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
